bias_weight_table_sat: RTL and testbench
========================================

Name: bias_weight_table_sat

Overview:
- Parametrised successor of the bias-free neural predictor's bias weight table.
- Holds DEPTH signed saturating weights and serves a registered prediction read.
- Performs the training read-modify-write internally: taken increments, not-taken decrements, with saturation.
- Adds a post-reset initialisation sweep, update-to-read bypass, and a HIST_LEN-deep history shift register of predicted weights for the perceptron adder tree.

Parameters:
- DEPTH, 1024, number of table entries (power of two).
- IDX_W, 10, index width (log2 DEPTH).
- WGT_W, 2, weight width, signed two's complement, minimum 2.
- HIST_LEN, 3, number of past predicted weights kept in the history register.
- INIT_VAL, 0, value written to every entry during the init sweep (signed, within range).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- rd_en  in  1  prediction read request.
- rd_idx  in  IDX_W  prediction index.
- weight  out  WGT_W  predicted weight, registered.
- weight_vld  out  1  weight valid, one cycle after an accepted rd_en.
- upd_en  in  1  training update request.
- upd_idx  in  IDX_W  index to train.
- upd_taken  in  1  1 = increment, 0 = decrement.
- ready  out  1  high once the init sweep has finished; low during init.
- hist  out  HIST_LEN*WGT_W  past predicted weights; newest in the LSB slice.

Behaviour:
- Reset (async, immediate):
  - weight=0, weight_vld=0, hist=0, ready=0.
  - FSM enters INIT with init_ptr=0.
  - Table contents are not reset directly.
- FSM states:
  - INIT: each cycle write INIT_VAL to table[init_ptr] and increment init_ptr. When init_ptr==DEPTH-1 is written, go to RUN next cycle. Sweep takes exactly DEPTH cycles.
  - RUN: ready=1. Terminal until rst.
- Reset asserted mid-sweep or in RUN restarts INIT from 0.
- During INIT:
  - rd_en and upd_en are ignored (no state change).
  - weight_vld stays 0 and hist holds.
- Read (RUN):
  - rd_en at edge N gives weight=table[rd_idx] and weight_vld=1 after edge N.
  - Latency 1. No back-pressure; a new read may be issued every cycle.
  - rd_en=0: weight_vld=0 and weight holds its last value.
- Update (RUN): upd_en at edge N writes sat(table[upd_idx] ± 1) at edge N.
  - Saturation range is -2^(WGT_W-1) .. 2^(WGT_W-1)-1. At the bound, the value stays put.
  - Arithmetic is done at WGT_W+1 bits, then clamped. Never wraps.
- Read/update collision (same cycle, rd_idx==upd_idx): weight returns the post-update (saturated) value. This is a write-first bypass.
- History: on every cycle with weight_vld going 1 (accepted read), hist <= {hist[(HIST_LEN-1)*WGT_W-1:0], new weight}. It holds otherwise.
- Back-to-back updates to the same index on consecutive cycles each see the previous cycle's write, so there is no lost update.
- upd_en and rd_en are fully independent; both may be active every cycle.

Test Plan:
- Reset sweep: assert rst 3 cycles, release, DEPTH=16 build → ready rises exactly 16 cycles after release. rd_en during the sweep gives weight_vld=0. Reading every index afterwards returns 0.
- Positive saturation (WGT_W=2): three upd_taken=1 updates to idx 5 → table[5] reads 1 (not -2). A following decrement reads 0.
- Negative saturation: four decrements to idx 7 → reads -2 (2'b10). Next decrement still reads -2. Next increment reads -1.
- Collision bypass: table[3]=0; same cycle rd_en, rd_idx=3, upd_en, upd_idx=3, upd_taken=1 → next cycle weight=1, weight_vld=1.
- History: HIST_LEN=3; read weights 1, -1, 0, -2 on consecutive cycles → hist = {-1, 0, -2}, newest in the LSBs. An idle rd_en=0 cycle leaves hist unchanged.
- Reset mid-operation: pulse rst while in RUN after training idx 2 to 1 → ready drops asynchronously, and weight/weight_vld/hist go to 0. After the sweep, table[2] reads INIT_VAL.

Source files
------------

// File: rtl/bias_weight_table_sat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bias_weight_table_sat: saturating signed bias weight table with init      |
// | sweep, write-first read bypass and predicted-weight history. Rev 1.0      |
// +--------------------------------------------------------------------------+
module bias_weight_table_sat #(
  parameter int DEPTH    = 1024,
  parameter int IDX_W    = 10,
  parameter int WGT_W    = 2,
  parameter int HIST_LEN = 3,
  parameter int INIT_VAL = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_en_i,
  input  logic [IDX_W-1:0]          rd_idx_i,
  output logic [WGT_W-1:0]          weight_o,
  output logic                      weight_vld_o,
  input  logic                      upd_en_i,
  input  logic [IDX_W-1:0]          upd_idx_i,
  input  logic                      upd_taken_i,
  output logic                      ready_o,
  output logic [HIST_LEN*WGT_W-1:0] hist_o
);

  localparam logic [IDX_W-1:0]        C_LAST    = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]        C_PTR_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [WGT_W-1:0]        C_INIT    = INIT_VAL[WGT_W-1:0];
  localparam logic signed [WGT_W:0]   C_ONE     = {{WGT_W{1'b0}}, 1'b1};
  localparam logic signed [WGT_W:0]   C_MAX     = {2'b00, {(WGT_W-1){1'b1}}};
  localparam logic signed [WGT_W:0]   C_MIN     = {2'b11, {(WGT_W-1){1'b0}}};
  localparam logic [WGT_W-1:0]        C_MAX_W   = {1'b0, {(WGT_W-1){1'b1}}};
  localparam logic [WGT_W-1:0]        C_MIN_W   = {1'b1, {(WGT_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                      state_q;
  logic [IDX_W-1:0]            init_ptr_q;
  logic                        ready_q;
  logic [WGT_W-1:0]            weight_q;
  logic                        weight_vld_q;
  logic [HIST_LEN*WGT_W-1:0]   hist_q;
  logic [HIST_LEN*WGT_W-1:0]   hist_d;
  logic [WGT_W-1:0]            mem_q [DEPTH];

  logic                        run_d;
  logic [WGT_W-1:0]            upd_cur_d;
  logic signed [WGT_W:0]       upd_ext_d;
  logic signed [WGT_W:0]       upd_sum_d;
  logic [WGT_W-1:0]            upd_new_d;
  logic [WGT_W-1:0]            rd_wgt_d;

  assign run_d = (state_q == ST_RUN);

  // Training step is widened by one bit so the +/-1 can never wrap before clamping.
  always_comb begin
    upd_cur_d = mem_q[upd_idx_i];
    upd_ext_d = {upd_cur_d[WGT_W-1], upd_cur_d};
    upd_sum_d = upd_taken_i ? (upd_ext_d + C_ONE) : (upd_ext_d - C_ONE);
    if (upd_sum_d > C_MAX) begin
      upd_new_d = C_MAX_W;
    end else if (upd_sum_d < C_MIN) begin
      upd_new_d = C_MIN_W;
    end else begin
      upd_new_d = upd_sum_d[WGT_W-1:0];
    end
    rd_wgt_d = (upd_en_i && (upd_idx_i == rd_idx_i)) ? upd_new_d : mem_q[rd_idx_i];
  end

  generate
    if (HIST_LEN > 1) begin : g_hist_shift
      assign hist_d = {hist_q[(HIST_LEN-1)*WGT_W-1:0], rd_wgt_d};
    end else begin : g_hist_single
      assign hist_d = rd_wgt_d;
    end
  endgenerate

  // Table storage has no reset; the sweep owns the write port while in INIT.
  always_ff @(posedge clk) begin
    if (!run_d) begin
      mem_q[init_ptr_q] <= C_INIT;
    end else if (upd_en_i) begin
      mem_q[upd_idx_i] <= upd_new_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      ready_q      <= 1'b0;
      weight_q     <= '0;
      weight_vld_q <= 1'b0;
      hist_q       <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_ptr_q   <= init_ptr_q + C_PTR_ONE;
          weight_vld_q <= 1'b0;
          if (init_ptr_q == C_LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          weight_vld_q <= rd_en_i;
          if (rd_en_i) begin
            weight_q <= rd_wgt_d;
            hist_q   <= hist_d;
          end
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign weight_o     = weight_q;
  assign weight_vld_o = weight_vld_q;
  assign ready_o      = ready_q;
  assign hist_o       = hist_q;

endmodule
`default_nettype wire

// File: tb/tb_bias_weight_table_sat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bias_weight_table_sat: bench for bias_weight_table_sat against a       |
// | behavioural table model. Rev 1.0                                          |
// +--------------------------------------------------------------------------+
module tb_bias_weight_table_sat;

  localparam int DEPTH    = 16;
  localparam int IDX_W    = 4;
  localparam int WGT_W    = 2;
  localparam int HIST_LEN = 3;
  localparam int INIT_VAL = 0;
  localparam int MAXV     = (1 << (WGT_W - 1)) - 1;
  localparam int MINV     = -(1 << (WGT_W - 1));

  logic                      clk;
  logic                      rst;
  logic                      rd_en_i;
  logic [IDX_W-1:0]          rd_idx_i;
  logic [WGT_W-1:0]          weight_o;
  logic                      weight_vld_o;
  logic                      upd_en_i;
  logic [IDX_W-1:0]          upd_idx_i;
  logic                      upd_taken_i;
  logic                      ready_o;
  logic [HIST_LEN*WGT_W-1:0] hist_o;

  int checks;
  int failures;

  // Reference model state
  int  m_tbl [DEPTH];
  int  m_hist [HIST_LEN];
  int  m_w;
  int  m_vld;
  int  m_cnt;
  bit  m_run;

  bias_weight_table_sat #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .WGT_W(WGT_W), .HIST_LEN(HIST_LEN), .INIT_VAL(INIT_VAL)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i),
    .weight_o(weight_o), .weight_vld_o(weight_vld_o),
    .upd_en_i(upd_en_i), .upd_idx_i(upd_idx_i), .upd_taken_i(upd_taken_i),
    .ready_o(ready_o), .hist_o(hist_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WGT_W-1:0] to_w(input int v);
    logic [31:0] t;
    t = v;
    return t[WGT_W-1:0];
  endfunction

  function automatic logic [HIST_LEN*WGT_W-1:0] pack_hist();
    logic [HIST_LEN*WGT_W-1:0] e;
    e = '0;
    for (int i = 0; i < HIST_LEN; i++) e[i*WGT_W +: WGT_W] = to_w(m_hist[i]);
    return e;
  endfunction

  function automatic int sat(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = INIT_VAL;
    for (int i = 0; i < HIST_LEN; i++) m_hist[i] = 0;
    m_w = 0; m_vld = 0; m_cnt = 0; m_run = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ready"}, ready_o, m_run);
    chk({tag, ".vld"}, weight_vld_o, m_vld);
    chk({tag, ".weight"}, weight_o, to_w(m_w));
    chk({tag, ".hist"}, hist_o, pack_hist());
  endtask

  // One clock: drive, advance the model by the same edge, compare.
  task automatic cycle(input bit rd, input int ridx, input bit upd, input int uidx,
                       input bit taken, input string tag);
    rd_en_i = rd; rd_idx_i = IDX_W'(ridx);
    upd_en_i = upd; upd_idx_i = IDX_W'(uidx); upd_taken_i = taken;
    @(posedge clk);
    #1;
    if (!m_run) begin
      m_cnt++;
      m_vld = 0;
      if (m_cnt == DEPTH) m_run = 1'b1;
    end else begin
      if (upd) m_tbl[uidx] = sat(m_tbl[uidx] + (taken ? 1 : -1));
      if (rd) begin
        m_w = m_tbl[ridx];
        m_vld = 1;
        for (int i = HIST_LEN - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = m_w;
      end else begin
        m_vld = 0;
      end
    end
    check_outputs(tag);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; rd_en_i = 0; rd_idx_i = '0; upd_en_i = 0; upd_idx_i = '0; upd_taken_i = 0;
    model_reset();
    #2;
    apply_reset("por");

    // Sweep with reads and updates requested throughout; both must be ignored.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, i, 1'b1, i, 1'b1, "sweep");
    chk("sweep.ready_lit", ready_o, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, i, 1'b0, 0, 1'b0, "initread");

    // Positive saturation
    repeat (3) cycle(1'b0, 0, 1'b1, 5, 1'b1, "pinc");
    cycle(1'b1, 5, 1'b0, 0, 1'b0, "psat");
    chk("psat.lit", weight_o, 2'b01);
    cycle(1'b0, 0, 1'b1, 5, 1'b0, "pdec");
    cycle(1'b1, 5, 1'b0, 0, 1'b0, "pdecrd");
    chk("pdec.lit", weight_o, 2'b00);

    // Negative saturation
    repeat (4) cycle(1'b0, 0, 1'b1, 7, 1'b0, "ndec");
    cycle(1'b1, 7, 1'b0, 0, 1'b0, "nsat");
    chk("nsat.lit", weight_o, 2'b10);
    cycle(1'b1, 7, 1'b1, 7, 1'b0, "nsat2");
    chk("nsat2.lit", weight_o, 2'b10);
    cycle(1'b0, 0, 1'b1, 7, 1'b1, "ninc");
    cycle(1'b1, 7, 1'b0, 0, 1'b0, "nincrd");
    chk("ninc.lit", weight_o, 2'b11);

    // Collision bypass
    cycle(1'b1, 3, 1'b1, 3, 1'b1, "bypass");
    chk("bypass.lit", weight_o, 2'b01);
    chk("bypass.vld_lit", weight_vld_o, 1'b1);

    // History: prepare 8=1, 9=-1, 10=0, 11=-2
    cycle(1'b0, 0, 1'b1, 8, 1'b1, "hprep");
    cycle(1'b0, 0, 1'b1, 9, 1'b0, "hprep");
    cycle(1'b0, 0, 1'b1, 11, 1'b0, "hprep");
    cycle(1'b0, 0, 1'b1, 11, 1'b0, "hprep");
    cycle(1'b1, 8, 1'b0, 0, 1'b0, "hrd");
    cycle(1'b1, 9, 1'b0, 0, 1'b0, "hrd");
    cycle(1'b1, 10, 1'b0, 0, 1'b0, "hrd");
    cycle(1'b1, 11, 1'b0, 0, 1'b0, "hrd");
    chk("hist.lit", hist_o, 6'b11_00_10);
    cycle(1'b0, 4, 1'b0, 0, 1'b0, "hidle");
    chk("hidle.lit", hist_o, 6'b11_00_10);
    chk("hidle.weight_lit", weight_o, 2'b10);

    // Randomised traffic; narrow index range to force collisions and saturation
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), "rand");
    end

    // Reset mid-operation
    repeat (3) cycle(1'b0, 0, 1'b1, 2, 1'b1, "train2");
    cycle(1'b1, 2, 1'b0, 0, 1'b0, "train2rd");
    chk("train2.lit", weight_o, 2'b01);
    #2;
    apply_reset("midrst");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 2, 1'b0, 0, 1'b0, "sweep2");
    cycle(1'b1, 2, 1'b0, 0, 1'b0, "after2");
    chk("after2.lit", weight_o, to_w(INIT_VAL));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
